// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and full period of an asynchronous PWM input
// in clk cycles, and flags inputs that stop toggling (stuck low or stuck high).
// Results use the same encoding as the PWM generator's period/duty_cycle inputs.

module pwm_capture #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] duty_cycle,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_level
);

   // A synchronizer shorter than two flops is not safe, so clamp it.
   localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;

   logic [SYNC_N-1:0] sync_q;
   logic              s;
   logic              s_d;
   logic              rise;
   logic              fall;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [WIDTH-1:0]  counter;
   logic [WIDTH-1:0]  counter_nxt;
   logic [WIDTH-1:0]  counter_inc;
   logic [WIDTH-1:0]  high_cnt;
   logic [WIDTH-1:0]  high_cnt_nxt;
   logic              fall_seen;
   logic              fall_seen_nxt;
   logic [WIDTH-1:0]  period_nxt;
   logic [WIDTH-1:0]  duty_cycle_nxt;
   logic              valid_nxt;
   logic              stuck_nxt;
   logic              stuck_level_nxt;

   // Bring pwm_in into the clk domain and keep one cycle of history for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_N-2:0], pwm_in};
         s_d    <= s;
      end
   end

   assign s    = sync_q[SYNC_N-1];
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   // Saturating increment; a timeout always fires before the counter could wrap.
   assign counter_inc = (counter == CNT_MAX) ? CNT_MAX : counter + CNT_ONE;

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         counter     <= '0;
         high_cnt    <= '0;
         fall_seen   <= 1'b0;
         period      <= '0;
         duty_cycle  <= '0;
         valid       <= 1'b0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         state       <= state_nxt;
         counter     <= counter_nxt;
         high_cnt    <= high_cnt_nxt;
         fall_seen   <= fall_seen_nxt;
         period      <= period_nxt;
         duty_cycle  <= duty_cycle_nxt;
         valid       <= valid_nxt;
         stuck       <= stuck_nxt;
         stuck_level <= stuck_level_nxt;
      end
   end

   // Next-state and next-output logic; everything holds unless a branch says otherwise.
   always_comb begin
      state_nxt       = state;
      counter_nxt     = counter;
      high_cnt_nxt    = high_cnt;
      fall_seen_nxt   = fall_seen;
      period_nxt      = period;
      duty_cycle_nxt  = duty_cycle;
      valid_nxt       = 1'b0;
      stuck_nxt       = stuck;
      stuck_level_nxt = stuck_level;

      if (!enable) begin
         // Disabling drops any in-flight measurement; results are kept.
         state_nxt     = ST_IDLE;
         counter_nxt   = CNT_ZERO;
         fall_seen_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt     = ST_ARM;
               counter_nxt   = CNT_ZERO;
               fall_seen_nxt = 1'b0;
            end

            ST_ARM: begin
               // Counter here measures time since the last edge, for stuck detection.
               if (rise) begin
                  state_nxt     = ST_MEASURE;
                  counter_nxt   = CNT_ONE;
                  fall_seen_nxt = 1'b0;
                  stuck_nxt     = 1'b0;
               end else if (counter == CNT_MAX) begin
                  stuck_nxt       = 1'b1;
                  stuck_level_nxt = s;
                  counter_nxt     = CNT_ZERO;
               end else if (fall) begin
                  counter_nxt = CNT_ZERO;
               end else begin
                  counter_nxt = counter_inc;
               end
            end

            ST_MEASURE: begin
               // Rise takes priority over a coincident timeout.
               if (rise) begin
                  if (fall_seen) begin
                     period_nxt     = counter;
                     duty_cycle_nxt = high_cnt;
                     valid_nxt      = 1'b1;
                  end
                  counter_nxt   = CNT_ONE;
                  fall_seen_nxt = 1'b0;
                  stuck_nxt     = 1'b0;
               end else if (counter == CNT_MAX) begin
                  stuck_nxt       = 1'b1;
                  stuck_level_nxt = s;
                  state_nxt       = ST_ARM;
                  counter_nxt     = CNT_ZERO;
                  fall_seen_nxt   = 1'b0;
               end else begin
                  counter_nxt = counter_inc;
                  if (fall) begin
                     high_cnt_nxt  = counter;
                     fall_seen_nxt = 1'b1;
                  end
               end
            end

            default: begin
               state_nxt     = ST_IDLE;
               counter_nxt   = CNT_ZERO;
               fall_seen_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM waveforms into a WIDTH=16 and a WIDTH=8 capture
// instance sharing the same inputs, and checks results against H/L arithmetic.

module tb_pwm_capture;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        pwm_in;

   logic [15:0] p16, d16;
   logic        v16, s16, sl16;
   logic [7:0]  p8, d8;
   logic        v8, s8, sl8;

   int errors;
   int checks;

   int exp_p;
   int exp_d;
   bit mon_en;

   int          vcnt    [2];
   logic [15:0] mp      [2];
   logic [15:0] md      [2];
   logic        mv      [2];
   logic [15:0] prev_p  [2];
   logic [15:0] prev_d  [2];
   logic        prev_v  [2];

   typedef struct {
      int h;
      int l;
      int n;
      int ep;
      int ed;
   } vec_t;

   vec_t vecs [6];

   pwm_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
      .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
      .period(p16), .duty_cycle(d16), .valid(v16), .stuck(s16), .stuck_level(sl16)
   );

   pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
      .period(p8), .duty_cycle(d8), .valid(v8), .stuck(s8), .stuck_level(sl8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      mp[0] = p16;
      md[0] = d16;
      mv[0] = v16;
      mp[1] = {8'h00, p8};
      md[1] = {8'h00, d8};
      mv[1] = v8;
   end

   // Every valid must carry the expected H+L / H pair, be one cycle wide,
   // and results must never move without valid.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mon_en) begin
            if (mv[i]) begin
               checks++;
               vcnt[i]++;
               if (mp[i] !== 16'(exp_p) || md[i] !== 16'(exp_d)) begin
                  errors++;
                  $display("FAIL valid_value[%s] got period=%0d duty=%0d want period=%0d duty=%0d",
                           (i == 0) ? "w16" : "w8", mp[i], md[i], exp_p, exp_d);
               end
               if (prev_v[i]) begin
                  errors++;
                  $display("FAIL valid_width[%s] got valid high 2 cycles want 1",
                           (i == 0) ? "w16" : "w8");
               end
            end else if (mp[i] !== prev_p[i] || md[i] !== prev_d[i]) begin
               checks++;
               errors++;
               $display("FAIL hold_without_valid[%s] got period=%0d duty=%0d want period=%0d duty=%0d",
                        (i == 0) ? "w16" : "w8", mp[i], md[i], prev_p[i], prev_d[i]);
            end
         end
         prev_p[i] = mp[i];
         prev_d[i] = md[i];
         prev_v[i] = mv[i];
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      reset  = 1'b1;
      tick(2);
      reset  = 1'b0;
      tick(1);
      mon_en = 1'b1;
   endtask

   // Return to IDLE with the input low, then re-enable so the next rise only arms.
   task automatic clean_start();
      pwm_in = 1'b0;
      enable = 1'b0;
      tick(4);
      enable = 1'b1;
      tick(2);
   endtask

   task automatic run_periods(input int h, input int l, input int n);
      for (int k = 0; k < n; k++) begin
         pwm_in = 1'b1;
         tick(h);
         pwm_in = 1'b0;
         tick(l);
      end
   endtask

   // A final rise closes the last driven period, then let the pipeline drain.
   task automatic tail();
      pwm_in = 1'b1;
      tick(1);
      pwm_in = 1'b0;
      tick(10);
   endtask

   task automatic clear_counts();
      vcnt[0] = 0;
      vcnt[1] = 0;
   endtask

   task automatic run_vector(input int h, input int l, input int n, input int ep, input int ed,
                             input string nm);
      clean_start();
      exp_p = ep;
      exp_d = ed;
      clear_counts();
      run_periods(h, l, n);
      tail();
      chk({nm, "_count_w16"}, vcnt[0], n);
      chk({nm, "_count_w8"}, vcnt[1], n);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      mon_en = 1'b0;
      reset  = 1'b1;
      enable = 1'b0;
      pwm_in = 1'b0;
      exp_p  = 0;
      exp_d  = 0;
      clear_counts();

      vecs[0] = '{h: 3,   l: 5,   n: 4,  ep: 8,   ed: 3};
      vecs[1] = '{h: 25,  l: 75,  n: 10, ep: 100, ed: 25};
      vecs[2] = '{h: 1,   l: 1,   n: 5,  ep: 2,   ed: 1};
      vecs[3] = '{h: 1,   l: 6,   n: 3,  ep: 7,   ed: 1};
      vecs[4] = '{h: 6,   l: 1,   n: 3,  ep: 7,   ed: 6};
      vecs[5] = '{h: 100, l: 154, n: 2,  ep: 254, ed: 100};

      // Reset state
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("rst_period_w16", int'(p16), 0);
      chk("rst_duty_w16",   int'(d16), 0);
      chk("rst_valid_w16",  int'(v16), 0);
      chk("rst_stuck_w16",  int'(s16), 0);
      chk("rst_level_w16",  int'(sl16), 0);
      chk("rst_period_w8",  int'(p8), 0);
      chk("rst_stuck_w8",   int'(s8), 0);
      mon_en = 1'b1;

      // Table-driven waveforms
      for (int i = 0; i < 6; i++)
         run_vector(vecs[i].h, vecs[i].l, vecs[i].n, vecs[i].ep, vecs[i].ed,
                    $sformatf("vec%0d", i));

      // Randomized waveforms against H+L / H arithmetic
      for (int i = 0; i < 8; i++) begin
         int h, l;
         h = int'($urandom_range(1, 30));
         l = int'($urandom_range(1, 30));
         run_vector(h, l, 3, h + l, h, $sformatf("rnd%0d_h%0d_l%0d", i, h, l));
      end

      // Stuck low on the narrow instance, then recovery with H=2/L=2
      do_reset();
      clear_counts();
      enable = 1'b1;
      pwm_in = 1'b0;
      tick(300);
      chk("stuck0_w8",       int'(s8), 1);
      chk("stuck0_level_w8", int'(sl8), 0);
      chk("stuck0_w16",      int'(s16), 0);
      chk("stuck0_novalid",  vcnt[0] + vcnt[1], 0);
      exp_p = 4;
      exp_d = 2;
      run_periods(2, 2, 1);
      chk("stuck0_clear_w8", int'(s8), 0);
      run_periods(2, 2, 3);
      tail();
      chk("recover_count_w8",  vcnt[1], 4);
      chk("recover_count_w16", vcnt[0], 4);
      chk("recover_level_w8",  int'(sl8), 0);

      // Stuck high while measuring: old results kept
      clean_start();
      exp_p = 8;
      exp_d = 3;
      clear_counts();
      run_periods(3, 5, 2);
      pwm_in = 1'b1;
      tick(300);
      chk("stuck1_w8",        int'(s8), 1);
      chk("stuck1_level_w8",  int'(sl8), 1);
      chk("stuck1_period_w8", int'(p8), 8);
      chk("stuck1_duty_w8",   int'(d8), 3);
      chk("stuck1_w16",       int'(s16), 0);
      chk("stuck1_count_w8",  vcnt[1], 2);
      pwm_in = 1'b0;
      tick(6);

      // Reset two cycles after a fall aborts the measurement
      clean_start();
      exp_p = 8;
      exp_d = 3;
      run_periods(3, 5, 2);
      pwm_in = 1'b1;
      tick(3);
      pwm_in = 1'b0;
      tick(2);
      mon_en = 1'b0;
      reset  = 1'b1;
      tick(1);
      reset  = 1'b0;
      chk("midrst_period_w16", int'(p16), 0);
      chk("midrst_duty_w16",   int'(d16), 0);
      chk("midrst_valid_w16",  int'(v16), 0);
      chk("midrst_period_w8",  int'(p8), 0);
      chk("midrst_stuck_w8",   int'(s8), 0);
      chk("midrst_level_w8",   int'(sl8), 0);
      tick(3);
      mon_en = 1'b1;
      clear_counts();
      run_periods(3, 5, 1);
      chk("midrst_arm_only", vcnt[0] + vcnt[1], 0);
      run_periods(3, 5, 1);
      tail();
      chk("midrst_count_w16", vcnt[0], 2);
      chk("midrst_count_w8",  vcnt[1], 2);

      // Enable dropped for 4 cycles during a high phase
      clean_start();
      exp_p = 12;
      exp_d = 6;
      clear_counts();
      run_periods(6, 6, 2);
      pwm_in = 1'b1;
      tick(1);
      enable = 1'b0;
      tick(4);
      chk("dis_hold_period_w16", int'(p16), 12);
      chk("dis_hold_duty_w8",    int'(d8), 6);
      chk("dis_count_w16",       vcnt[0], 1);
      enable = 1'b1;
      tick(1);
      pwm_in = 1'b0;
      tick(6);
      run_periods(6, 6, 1);
      chk("reen_no_early_w16", vcnt[0], 1);
      chk("reen_no_early_w8",  vcnt[1], 1);
      run_periods(6, 6, 1);
      tail();
      chk("reen_count_w16", vcnt[0], 3);
      chk("reen_count_w8",  vcnt[1], 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
